// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for memory hold, taken branch and load-use; HAZARD_PERF_EN adds a stall-cycle counter
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              stall_wb,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] perf_stall_cycles
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
    localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        mem_hold, load_use, hold_o, branch_o, lu_o;
    // next state and wait counter; the counter restarts at zero whenever RUN is entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                state_d = (mem_req && !mem_ready) ? MEM_WAIT : RUN;
                cnt_d   = (mem_req && !mem_ready) ? 16'd1 : 16'd0;
            end
            MEM_WAIT: begin
                state_d = mem_ready ? RUN : (cnt_q == TMO) ? ERROR : MEM_WAIT;
                cnt_d   = mem_ready ? 16'd0 : (cnt_q == TMO) ? cnt_q : cnt_q + 16'd1;
            end
            default: state_d = ERROR;
        endcase
        mem_timeout_d = (state_d == ERROR);
    end
    // state, counter and error flag registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end
    // prioritised stall/flush decode, forced quiet while reset is held
    always_comb begin
        mem_hold  = (state_q == RUN && mem_req && !mem_ready) || (state_q == MEM_WAIT && !mem_ready) || (state_q == ERROR);
        load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        hold_o    = !rst && mem_hold;
        branch_o  = !rst && !mem_hold && ex_branch_taken;
        lu_o      = !rst && !mem_hold && !ex_branch_taken && load_use;
        stall_if  = hold_o || lu_o;
        stall_id  = hold_o || lu_o;
        stall_ex  = hold_o;
        stall_mem = hold_o;
        stall_wb  = hold_o;
        flush_id  = branch_o;
        flush_ex  = branch_o || lu_o;
    end
    assign mem_timeout = mem_timeout_q;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;
    // saturating count of clock edges that saw stall_if high
    always_comb begin
        perf_d = (stall_if && perf_q != {PERF_W{1'b1}}) ? perf_q + 1'b1 : perf_q;
    end
    // performance counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end
    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of the hazard sequencer against a behavioural model
module tb_pipeline_hazard_ctrl;
    localparam int TMO = 4;
    localparam int PW  = 4;
    logic clk = 0, rst = 1;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex, mem_timeout;
    logic [PW-1:0] perf_stall_cycles;
    int vec = 0, err = 0;
    bit m_err, m_waiting;
    int m_waits, m_perf;
    logic [6:0] e;
    wire [6:0] out_v = {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .stall_wb(stall_wb), .flush_id(flush_id), .flush_ex(flush_ex), .mem_timeout(mem_timeout),
        .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clk = ~clk;

    // {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex}
    function automatic logic [6:0] exp_out();
        bit hold, lu;
        if (rst) return 7'b0;
        hold = m_err || ((m_waiting || mem_req) && !mem_ready);
        lu = ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (hold) return 7'b1111100;
        if (ex_branch_taken) return 7'b0000011;
        if (lu) return 7'b1100001;
        return 7'b0;
    endfunction

    function automatic logic [PW-1:0] exp_perf();
`ifdef HAZARD_PERF_EN
        return PW'(m_perf);
`else
        return '0;
`endif
    endfunction

    task automatic model_edge();
        logic [6:0] o;
        bit hold;
        if (rst) begin
            m_err = 0; m_waiting = 0; m_waits = 0; m_perf = 0;
            return;
        end
        o = exp_out();
        hold = m_err || ((m_waiting || mem_req) && !mem_ready);
        if (o[6] && m_perf < (1 << PW) - 1) m_perf++;
        if (!m_err) begin
            if (!hold) begin
                m_waiting = 0; m_waits = 0;
            end else if (m_waiting && m_waits == TMO) m_err = 1;
            else begin
                m_waiting = 1; m_waits++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clr_inputs();
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready} = '0;
    endtask

    task automatic do_reset();
        rst = 1; #1;
        model_edge();
        tick();
        clr_inputs();
        rst = 0; #1;
    endtask

    task automatic test_reset();
        rst = 1; mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        ex_mem_read = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
        #3;
        model_edge();
        vec++; if (out_v !== 7'b0) begin err++; $display("FAIL reset_outputs: got %b want %b", out_v, 7'b0); end
        vec++; if (mem_timeout !== 1'b0) begin err++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
        vec++; if (perf_stall_cycles !== '0) begin err++; $display("FAIL reset_perf: got %0d want 0", perf_stall_cycles); end
        tick();
        vec++; if (out_v !== 7'b0) begin err++; $display("FAIL reset_held: got %b want %b", out_v, 7'b0); end
        clr_inputs();
        rst = 0; #1;
        @(negedge clk);
        vec++; if (out_v !== 7'b0) begin err++; $display("FAIL reset_release: got %b want %b", out_v, 7'b0); end
        tick();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
        @(negedge clk);
        vec++; if (out_v !== 7'b1100001) begin err++; $display("FAIL load_use: got %b want %b", out_v, 7'b1100001); end
        tick();
        ex_rd = 0; id_rs1 = 0;
        @(negedge clk);
        vec++; if (out_v !== 7'b0) begin err++; $display("FAIL load_use_x0: got %b want %b", out_v, 7'b0); end
        tick();
        ex_rd = 9; id_rs1 = 1; id_uses_rs2 = 1; id_rs2 = 9;
        @(negedge clk);
        vec++; if (out_v !== 7'b1100001) begin err++; $display("FAIL load_use_rs2: got %b want %b", out_v, 7'b1100001); end
        tick();
        clr_inputs();
    endtask

    task automatic test_branch_priority();
        ex_mem_read = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5; ex_branch_taken = 1;
        @(negedge clk);
        vec++; if (out_v !== 7'b0000011) begin err++; $display("FAIL branch_over_lu: got %b want %b", out_v, 7'b0000011); end
        tick();
        clr_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            e = (i == 3) ? 7'b0 : 7'b1111100;
            vec++; if (out_v !== e) begin err++; $display("FAIL mem_wait_c%0d: got %b want %b", i, out_v, e); end
            tick();
        end
        mem_req = 0; mem_ready = 0;
        @(negedge clk);
        vec++; if (out_v !== 7'b0) begin err++; $display("FAIL mem_wait_after: got %b want %b", out_v, 7'b0); end
        vec++; if (perf_stall_cycles !== exp_perf()) begin err++; $display("FAIL mem_wait_perf: got %0d want %0d", perf_stall_cycles, exp_perf()); end
        tick();
    endtask

    task automatic test_hold_vs_branch();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec++; if (out_v !== 7'b1111100) begin err++; $display("FAIL hold_vs_branch_c%0d: got %b want %b", i, out_v, 7'b1111100); end
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        vec++; if (out_v !== 7'b0000011) begin err++; $display("FAIL branch_after_hold: got %b want %b", out_v, 7'b0000011); end
        tick();
        clr_inputs();
    endtask

    task automatic test_reset_mid_wait();
        mem_req = 1; mem_ready = 0;
        tick();
        @(negedge clk);
        vec++; if (out_v !== 7'b1111100) begin err++; $display("FAIL midwait_pre: got %b want %b", out_v, 7'b1111100); end
        rst = 1; #1;
        model_edge();
        vec++; if (out_v !== 7'b0) begin err++; $display("FAIL midwait_async: got %b want %b", out_v, 7'b0); end
        @(posedge clk); #1;
        mem_req = 0; rst = 0; #1;
        @(negedge clk);
        vec++; if (out_v !== 7'b0) begin err++; $display("FAIL midwait_release: got %b want %b", out_v, 7'b0); end
        vec++; if (mem_timeout !== 1'b0) begin err++; $display("FAIL midwait_timeout: got %b want 0", mem_timeout); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < TMO + 1; i++) begin
            @(negedge clk);
            vec++; if (mem_timeout !== 1'b0) begin err++; $display("FAIL timeout_early_c%0d: got %b want 0", i, mem_timeout); end
            vec++; if (out_v !== 7'b1111100) begin err++; $display("FAIL timeout_stall_c%0d: got %b want %b", i, out_v, 7'b1111100); end
            tick();
        end
        @(negedge clk);
        vec++; if (mem_timeout !== 1'b1) begin err++; $display("FAIL timeout_flag: got %b want 1", mem_timeout); end
        mem_ready = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = exp_out();
            vec++; if (out_v !== e) begin err++; $display("FAIL error_sticky_c%0d: got %b want %b", i, out_v, e); end
            vec++; if (mem_timeout !== m_err) begin err++; $display("FAIL error_flag_c%0d: got %b want %b", i, mem_timeout, m_err); end
            tick();
        end
        @(negedge clk);
        vec++; if (perf_stall_cycles !== exp_perf()) begin err++; $display("FAIL perf_saturate: got %0d want %0d", perf_stall_cycles, exp_perf()); end
        do_reset();
        @(negedge clk);
        vec++; if (out_v !== 7'b0 || mem_timeout !== 1'b0) begin err++; $display("FAIL error_cleared: got %b/%b want 0000000/0", out_v, mem_timeout); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); ex_rd = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); ex_mem_read = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            mem_req = 1'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e = exp_out();
            vec++; if (out_v !== e) begin err++; $display("FAIL random_%0d: got %b want %b", i, out_v, e); end
            vec++; if (mem_timeout !== m_err || perf_stall_cycles !== exp_perf()) begin
                err++; $display("FAIL random_state_%0d: timeout %b want %b, perf %0d want %0d", i, mem_timeout, m_err, perf_stall_cycles, exp_perf());
            end
            tick();
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
        end
        clr_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_hold_vs_branch();
        test_reset_mid_wait();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the stall inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the flush (bubble) inputs of IF/ID and ID/EX. It resolves three hazard sources with a fixed priority: multi-cycle data-memory access, taken branch, and load-use dependency. It also watches memory handshakes for a hung access.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: maximum consecutive wait cycles on one memory access before error; range 1..65535.
- PERF_W, default 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  5  source register 1 of the instruction in ID
- id_rs2  in  5  source register 2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_req  in  1  MEM stage presents a load/store this cycle
- mem_ready  in  1  data memory/MMIO completes the presented access this cycle
- stall_if, stall_id, stall_ex, stall_mem, stall_wb  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM / MEM-WB
- flush_id  out  1  load bubble into IF/ID
- flush_ex  out  1  load bubble into ID/EX
- mem_timeout  out  1  sticky error flag
- perf_stall_cycles  out  PERF_W  stall-cycle count (see Configuration)

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state: RUN.
- Internal wait counter: 16 bits, cleared on reset and on every transition into RUN.
- mem_hold = (RUN and mem_req and !mem_ready) or (MEM_WAIT and !mem_ready) or ERROR.
- Priority 1, memory hold: when mem_hold=1, all five stalls are 1 and both flushes are 0. Holding MEM/WB repeats an idempotent register write.
- Priority 2, taken branch: applies when mem_hold=0 and ex_branch_taken=1. flush_id=1 and flush_ex=1; all stalls are 0. Any load-use condition is ignored because the ID instruction is squashed.
- Priority 3, load-use: applies when mem_hold=0, no taken branch, ex_mem_read=1, ex_rd!=0, and (id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd). Outputs: stall_if=1, stall_id=1, flush_ex=1; all other outputs 0. Exactly one bubble is inserted per load, because the dependent instruction sees the load in MEM on the next cycle.
- Otherwise: all stalls and flushes are 0.
- RUN transitions: mem_req and !mem_ready -> MEM_WAIT, with the counter set to 1. mem_req and mem_ready completes in the same cycle, so there is no stall and the state stays RUN.
- MEM_WAIT transitions:
  - mem_ready=1 -> RUN, and the stall drops in that same cycle.
  - counter==MEM_TIMEOUT and mem_ready=0 -> ERROR.
  - otherwise the counter increments.
- ERROR: every stall is held at 1 and mem_timeout=1. The only exit is rst.
- mem_timeout is 0 in RUN and MEM_WAIT.

## Timing
- Reset values: state RUN, counter 0, mem_timeout 0, perf_stall_cycles 0. All stall/flush outputs are 0 while rst is asserted.
- Stall and flush outputs are combinational from state and current inputs (zero-cycle latency) and must be valid before the same clk edge that the pipeline registers sample.
- mem_timeout is registered; it asserts the cycle after the ERROR transition edge.
- A single access held N cycles (mem_ready arrives in cycle N+1 after first presentation) produces exactly N stall cycles.
- Timeout: with mem_ready stuck at 0, ERROR is entered on the edge ending wait cycle MEM_TIMEOUT.
- rst asserted mid-MEM_WAIT aborts the wait immediately (asynchronous); the outputs return to reset values without waiting for a clock edge.
- A simultaneous memory hold and branch: the branch flush is deferred, not lost. EX is stalled, so ex_branch_taken is re-presented once the hold releases.

## Configuration
- HAZARD_PERF_EN defined: perf_stall_cycles increments by 1 on every clock edge where stall_if was 1, including memory, load-use and ERROR stalls. It saturates at all-ones and clears on reset.
- HAZARD_PERF_EN undefined: no counter logic is built and perf_stall_cycles is tied to 0.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_uses_rs1=1, id_rs1=5, mem_req=0 -> same cycle stall_if=stall_id=flush_ex=1, others 0. With ex_rd=0 instead -> all outputs 0.
- Branch beats load-use: same inputs as the load-use case plus ex_branch_taken=1 -> flush_id=flush_ex=1, all stalls 0.
- Memory wait: mem_req=1, mem_ready held 0 for 3 cycles then 1 -> all five stalls high for exactly 3 cycles and low in the ready cycle. The FSM goes RUN -> MEM_WAIT -> RUN. With HAZARD_PERF_EN, perf_stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready stuck 0 -> ERROR entered after 4 wait cycles and mem_timeout=1 on the next cycle. A later mem_ready=1 leaves all stalls 1; only rst clears them.
- Reset mid-wait: rst pulsed during the 2nd MEM_WAIT cycle -> all outputs 0 immediately. After release with mem_req=0, the FSM is in RUN with no stall.
- Memory hold vs. branch: mem_req=1, mem_ready=0, ex_branch_taken=1 -> all stalls 1, flushes 0. On the mem_ready=1 cycle -> flush_id=flush_ex=1.
